// File: rtl/inchan_rc_pkg.sv
// Shared flit format, port indices, FSM encoding and XY route helper for the input channel.
package inchan_rc_pkg;

    localparam int unsigned FLIT_W   = 34;
    localparam int unsigned TYPE_LSB = 32;
    localparam int unsigned TYPE_W   = 2;
    localparam int unsigned DSTX_LSB = 4;
    localparam int unsigned DSTY_LSB = 0;
    localparam int unsigned COORD_W  = 4;
    localparam int unsigned PORTW    = 3;

    typedef enum logic [TYPE_W-1:0] {
        FT_HEAD   = 2'b00,
        FT_BODY   = 2'b01,
        FT_TAIL   = 2'b10,
        FT_SINGLE = 2'b11
    } flit_type_e;

    localparam logic [PORTW-1:0] PORT_LOCAL = 3'd0;
    localparam logic [PORTW-1:0] PORT_W     = 3'd1;
    localparam logic [PORTW-1:0] PORT_S     = 3'd2;
    localparam logic [PORTW-1:0] PORT_E     = 3'd3;
    localparam logic [PORTW-1:0] PORT_N     = 3'd4;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_e;

    // Dimension-ordered routing: resolve X completely before Y.
    function automatic logic [PORTW-1:0] route_xy(
        input logic [COORD_W-1:0] dst_x,
        input logic [COORD_W-1:0] dst_y,
        input logic [COORD_W-1:0] here_x,
        input logic [COORD_W-1:0] here_y
    );
        logic [PORTW-1:0] p;
        if (dst_x > here_x)      p = PORT_E;
        else if (dst_x < here_x) p = PORT_W;
        else if (dst_y > here_y) p = PORT_S;
        else if (dst_y < here_y) p = PORT_N;
        else                     p = PORT_LOCAL;
        return p;
    endfunction

    // Flit opens a packet.
    function automatic logic is_head(input flit_type_e t);
        return (t == FT_HEAD) || (t == FT_SINGLE);
    endfunction

    // Flit closes a packet.
    function automatic logic is_tail(input flit_type_e t);
        return (t == FT_TAIL) || (t == FT_SINGLE);
    endfunction

endpackage

// File: rtl/inchan_rc_flitfifo.sv
// Small circular flit buffer; no write bypass when full, head data read combinationally.
module inchan_rc_flitfifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned DATAW = 34
) (
    input  logic             clk,
    input  logic             rst_,
    input  logic             push_i,
    input  logic [DATAW-1:0] wdata_i,
    input  logic             pop_i,
    output logic [DATAW-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [DATAW-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q,  count_d;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign rdata_o = mem_q[rd_ptr_q];

    // Pointer and occupancy next-state; pointers wrap naturally since DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        if (do_push && !do_pop)      count_d = count_q + CW'(1);
        else if (!do_push && do_pop) count_d = count_q - CW'(1);
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (rst_) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents need no reset because occupancy gates every read.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/inchan_rc.sv
// Router input channel: flit buffer, XY route computation and wormhole request hold.
module inchan_rc
    import inchan_rc_pkg::*;
#(
    parameter int unsigned XADDR = 0,
    parameter int unsigned YADDR = 0,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned DATAW = 34
) (
    input  logic             clk,
    input  logic             rst_,
    input  logic [DATAW-1:0] idata,
    input  logic             ivalid,
    output logic             irdy,
    output logic [DATAW-1:0] odata,
    output logic [PORTW-1:0] port,
    output logic             req,
    input  logic             grt,
    input  logic             nrdy,
    output logic             err
);

    state_e           state_q, state_d;
    logic [PORTW-1:0] port_q,  port_d;
    logic             err_q,   err_d;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic             send;
    flit_type_e       htype;
    logic [COORD_W-1:0] dst_x;
    logic [COORD_W-1:0] dst_y;

    assign irdy  = ~full;
    assign push  = ivalid & irdy;
    assign port  = port_q;
    assign err   = err_q;
    assign htype = flit_type_e'(odata[TYPE_LSB +: TYPE_W]);
    assign dst_x = odata[DSTX_LSB +: COORD_W];
    assign dst_y = odata[DSTY_LSB +: COORD_W];

    inchan_rc_flitfifo #(
        .DEPTH (DEPTH),
        .DATAW (DATAW)
    ) u_fifo (
        .clk     (clk),
        .rst_    (rst_),
        .push_i  (push),
        .wdata_i (idata),
        .pop_i   (pop),
        .rdata_o (odata),
        .full_o  (full),
        .empty_o (empty)
    );

    // Packet FSM: route heads in IDLE, drop stray body/tail flits, hold req across the packet.
    always_comb begin
        state_d = state_q;
        port_d  = port_q;
        err_d   = err_q;
        pop     = 1'b0;
        req     = 1'b0;
        send    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!empty) begin
                    if (is_head(htype)) begin
                        port_d  = route_xy(dst_x, dst_y, COORD_W'(XADDR), COORD_W'(YADDR));
                        state_d = ST_ACTIVE;
                    end else begin
                        pop   = 1'b1;
                        err_d = 1'b1;
                    end
                end
            end
            ST_ACTIVE: begin
                req  = 1'b1;
                send = ~empty & grt & nrdy;
                if (send) begin
                    pop = 1'b1;
                    if (is_tail(htype)) state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM state, latched output port and sticky error.
    always_ff @(posedge clk) begin
        if (rst_) begin
            state_q <= ST_IDLE;
            port_q  <= PORT_LOCAL;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            port_q  <= port_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_inchan_rc.sv
// Self-checking bench for inchan_rc at router (1,1) with a 4-entry buffer.
module tb_inchan_rc;

    localparam int unsigned XA = 1;
    localparam int unsigned YA = 1;
    localparam int unsigned DP = 4;
    localparam int unsigned DW = 34;

    localparam logic [1:0] T_HEAD   = 2'b00;
    localparam logic [1:0] T_BODY   = 2'b01;
    localparam logic [1:0] T_TAIL   = 2'b10;
    localparam logic [1:0] T_SINGLE = 2'b11;

    logic          clk;
    logic          rst_;
    logic [DW-1:0] idata;
    logic          ivalid;
    logic          irdy;
    logic [DW-1:0] odata;
    logic [2:0]    port;
    logic          req;
    logic          grt;
    logic          nrdy;
    logic          err;

    int tests;
    int fails;

    // Reference model: packet-level view of the channel.
    logic [DW-1:0] m_q [$];
    bit            m_act;
    logic [2:0]    m_port;
    bit            m_err;

    inchan_rc #(
        .XADDR (XA),
        .YADDR (YA),
        .DEPTH (DP),
        .DATAW (DW)
    ) dut (
        .clk    (clk),
        .rst_   (rst_),
        .idata  (idata),
        .ivalid (ivalid),
        .irdy   (irdy),
        .odata  (odata),
        .port   (port),
        .req    (req),
        .grt    (grt),
        .nrdy   (nrdy),
        .err    (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] mk(input logic [1:0] t, input logic [3:0] x,
                                         input logic [3:0] y, input logic [7:0] tag);
        return {t, tag, 16'h0000, x, y};
    endfunction

    function automatic logic [2:0] ref_route(input int dx, input int dy);
        if (dx > int'(XA)) return 3'd3;
        if (dx < int'(XA)) return 3'd1;
        if (dy > int'(YA)) return 3'd2;
        if (dy < int'(YA)) return 3'd4;
        return 3'd0;
    endfunction

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance the model by one clock using the inputs presented before the edge.
    task automatic model_step(input logic r, input logic iv, input logic [DW-1:0] d,
                              input logic g, input logic n);
        logic [1:0] t;
        bit acc;
        if (r) begin
            m_q.delete();
            m_act  = 1'b0;
            m_port = 3'd0;
            m_err  = 1'b0;
        end else begin
            acc = iv && (m_q.size() < DP);
            if (!m_act) begin
                if (m_q.size() > 0) begin
                    t = m_q[0][33:32];
                    if (t == T_HEAD || t == T_SINGLE) begin
                        m_port = ref_route(int'(m_q[0][7:4]), int'(m_q[0][3:0]));
                        m_act  = 1'b1;
                    end else begin
                        void'(m_q.pop_front());
                        m_err = 1'b1;
                    end
                end
            end else if (m_q.size() > 0 && g && n) begin
                t = m_q[0][33:32];
                void'(m_q.pop_front());
                if (t == T_TAIL || t == T_SINGLE) m_act = 1'b0;
            end
            if (acc) m_q.push_back(d);
        end
    endtask

    task automatic model_check();
        chk("req",  DW'(req),  DW'(m_act));
        chk("port", DW'(port), DW'(m_port));
        chk("irdy", DW'(irdy), DW'(m_q.size() < DP));
        chk("err",  DW'(err),  DW'(m_err));
        if (m_q.size() > 0) chk("odata", odata, m_q[0]);
    endtask

    // Present inputs, clock once, then compare DUT against the model.
    task automatic apply(input logic r, input logic iv, input logic [DW-1:0] d,
                         input logic g, input logic n);
        rst_   = r;
        ivalid = iv;
        idata  = d;
        grt    = g;
        nrdy   = n;
        model_step(r, iv, d, g, n);
        @(posedge clk);
        #1;
        rst_   = 1'b0;
        ivalid = 1'b0;
        model_check();
    endtask

    typedef struct {
        logic       iv;
        logic [1:0] t;
        logic [3:0] x;
        logic [3:0] y;
        logic       g;
        logic       n;
        logic       e_req;
        logic [2:0] e_port;
        logic       e_irdy;
        logic       e_err;
    } vec_t;

    vec_t tbl [12];

    function automatic vec_t v(input logic iv, input logic [1:0] t, input logic [3:0] x,
                               input logic [3:0] y, input logic g, input logic n,
                               input logic er, input logic [2:0] ep, input logic ei,
                               input logic ee);
        vec_t r;
        r.iv = iv; r.t = t; r.x = x; r.y = y; r.g = g; r.n = n;
        r.e_req = er; r.e_port = ep; r.e_irdy = ei; r.e_err = ee;
        return r;
    endfunction

    initial begin
        bit in_pkt;
        logic [1:0] gt;
        logic r, iv, g, n;
        tests  = 0;
        fails  = 0;
        m_act  = 1'b0;
        m_port = 3'd0;
        m_err  = 1'b0;
        rst_   = 1'b1;
        ivalid = 1'b0;
        idata  = '0;
        grt    = 1'b0;
        nrdy   = 1'b0;

        // Expected values are those seen just after the clock edge that consumes the row.
        // SINGLE to (3,1): routed east, popped on the first granted cycle.
        tbl[0]  = v(1, T_SINGLE, 3, 1, 1, 1, 0, 0, 1, 0);
        tbl[1]  = v(0, T_HEAD,   0, 0, 1, 1, 1, 3, 1, 0);
        tbl[2]  = v(0, T_HEAD,   0, 0, 1, 1, 0, 3, 1, 0);
        tbl[3]  = v(0, T_HEAD,   0, 0, 1, 1, 0, 3, 1, 0);
        // HEAD (1,0), BODY, TAIL with nrdy stalls: north, req held throughout.
        tbl[4]  = v(1, T_HEAD,   1, 0, 1, 0, 0, 3, 1, 0);
        tbl[5]  = v(1, T_BODY,   1, 0, 1, 0, 1, 4, 1, 0);
        tbl[6]  = v(1, T_TAIL,   1, 0, 1, 1, 1, 4, 1, 0);
        tbl[7]  = v(0, T_HEAD,   0, 0, 1, 0, 1, 4, 1, 0);
        tbl[8]  = v(0, T_HEAD,   0, 0, 1, 1, 1, 4, 1, 0);
        tbl[9]  = v(0, T_HEAD,   0, 0, 1, 0, 1, 4, 1, 0);
        tbl[10] = v(0, T_HEAD,   0, 0, 1, 1, 0, 4, 1, 0);
        tbl[11] = v(0, T_HEAD,   0, 0, 1, 1, 0, 4, 1, 0);

        // Power-on reset and reset-state check.
        apply(1, 0, '0, 0, 0);
        apply(1, 0, '0, 0, 0);
        chk("rst_req",  DW'(req),  DW'(0));
        chk("rst_port", DW'(port), DW'(0));
        chk("rst_irdy", DW'(irdy), DW'(1));
        chk("rst_err",  DW'(err),  DW'(0));

        // Table-driven directed vectors.
        for (int i = 0; i < 12; i++) begin
            apply(0, tbl[i].iv, mk(tbl[i].t, tbl[i].x, tbl[i].y, 8'(i)), tbl[i].g, tbl[i].n);
            chk($sformatf("tbl%0d_req", i),  DW'(req),  DW'(tbl[i].e_req));
            chk($sformatf("tbl%0d_port", i), DW'(port), DW'(tbl[i].e_port));
            chk($sformatf("tbl%0d_irdy", i), DW'(irdy), DW'(tbl[i].e_irdy));
            chk($sformatf("tbl%0d_err", i),  DW'(err),  DW'(tbl[i].e_err));
        end

        // Local head, FIFO empty mid-packet: req must hold until the tail leaves.
        apply(0, 1, mk(T_HEAD, 1, 1, 8'h20), 1, 1);
        apply(0, 0, '0, 1, 1);
        chk("loc_port", DW'(port), DW'(0));
        for (int i = 0; i < 5; i++) begin
            apply(0, 0, '0, 1, 1);
            chk($sformatf("loc_hold%0d", i), DW'(req), DW'(1));
        end
        apply(0, 1, mk(T_TAIL, 0, 0, 8'h21), 1, 1);
        chk("loc_tail_req", DW'(req), DW'(1));
        apply(0, 0, '0, 1, 1);
        chk("loc_drop_req", DW'(req), DW'(0));

        // Fill to DEPTH with no grant; a fifth write must be refused.
        apply(0, 1, mk(T_HEAD, 2, 1, 8'h30), 0, 0);
        apply(0, 1, mk(T_BODY, 0, 0, 8'h31), 0, 0);
        apply(0, 1, mk(T_BODY, 0, 0, 8'h32), 0, 0);
        apply(0, 1, mk(T_TAIL, 0, 0, 8'h33), 0, 0);
        chk("full_irdy", DW'(irdy), DW'(0));
        chk("full_port", DW'(port), DW'(3));
        apply(0, 1, mk(T_BODY, 0, 0, 8'h34), 0, 0);
        chk("full_head", odata, mk(T_HEAD, 2, 1, 8'h30));
        apply(0, 0, '0, 1, 1);
        chk("pop1_irdy", DW'(irdy), DW'(1));
        chk("pop1_head", odata, mk(T_BODY, 0, 0, 8'h31));
        for (int i = 0; i < 4; i++) apply(0, 0, '0, 1, 1);
        chk("drain_req", DW'(req), DW'(0));
        chk("drain_err", DW'(err), DW'(0));

        // Stray BODY in IDLE is dropped and flagged; following SINGLE routes west.
        apply(0, 1, mk(T_BODY, 0, 0, 8'h40), 0, 0);
        apply(0, 1, mk(T_SINGLE, 0, 1, 8'h41), 0, 0);
        chk("stray_err", DW'(err), DW'(1));
        apply(0, 0, '0, 0, 0);
        chk("west_port", DW'(port), DW'(1));
        chk("west_req",  DW'(req),  DW'(1));
        apply(0, 0, '0, 1, 1);
        apply(0, 0, '0, 1, 1);
        chk("sticky_err", DW'(err), DW'(1));

        // Reset mid-packet with two flits buffered.
        apply(0, 1, mk(T_HEAD, 2, 1, 8'h50), 0, 0);
        apply(0, 1, mk(T_BODY, 0, 0, 8'h51), 0, 0);
        chk("pre_rst_req", DW'(req), DW'(1));
        apply(1, 0, '0, 0, 0);
        chk("mid_rst_req",  DW'(req),  DW'(0));
        chk("mid_rst_port", DW'(port), DW'(0));
        chk("mid_rst_irdy", DW'(irdy), DW'(1));
        chk("mid_rst_err",  DW'(err),  DW'(0));
        apply(0, 0, '0, 1, 1);
        chk("mid_rst_empty", DW'(req), DW'(0));
        apply(0, 1, mk(T_SINGLE, 1, 2, 8'h52), 1, 1);
        apply(0, 0, '0, 1, 1);
        chk("post_rst_port", DW'(port), DW'(2));
        chk("post_rst_req",  DW'(req),  DW'(1));
        apply(0, 0, '0, 1, 1);
        apply(0, 0, '0, 1, 1);

        // Randomized traffic against the model, with occasional stray flits and resets.
        in_pkt = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            r  = ($urandom_range(0, 299) == 0);
            iv = ($urandom_range(0, 3) != 0);
            g  = ($urandom_range(0, 3) != 0);
            n  = ($urandom_range(0, 2) != 0);
            if (!in_pkt) begin
                case ($urandom_range(0, 9))
                    0:       gt = T_BODY;
                    1:       gt = T_TAIL;
                    2, 3, 4: gt = T_SINGLE;
                    default: gt = T_HEAD;
                endcase
            end else begin
                gt = ($urandom_range(0, 9) < 6) ? T_BODY : T_TAIL;
            end
            if (!r && iv && m_q.size() < DP) begin
                if (gt == T_HEAD) in_pkt = 1'b1;
                else if (gt == T_TAIL) in_pkt = 1'b0;
            end
            if (r) in_pkt = 1'b0;
            apply(r, iv, mk(gt, 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
                            8'($urandom)), g, n);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
